// File: rtl/proto_tx_frame_if.sv
// Result-channel and UART byte-side signal bundle for proto_tx_frame.
// master = miner/UART side, slave = the frame transmitter.
interface proto_tx_frame_if #(
    parameter int NUM_CH  = 4,
    parameter int NONCE_W = 64
);
    logic [NUM_CH-1:0]         res_valid;
    logic [NUM_CH-1:0]         res_found;
    logic [NUM_CH*NONCE_W-1:0] res_nonce;
    logic [NUM_CH-1:0]         res_ready;
    logic                      tx_busy;
    logic                      send;
    logic [7:0]                tx_data;
    logic                      frame_busy;

    modport master (
        output res_valid, res_found, res_nonce, tx_busy,
        input  res_ready, send, tx_data, frame_busy
    );

    modport slave (
        input  res_valid, res_found, res_nonce, tx_busy,
        output res_ready, send, tx_data, frame_busy
    );
endinterface

// File: rtl/proto_tx_frame.sv
// Round-robin result framer: SYNC, status {found,seq,ch}, nonce LSB-first.
// Define PROTO_TX_CHKSUM_EN to append an XOR checksum byte to every frame.
module proto_tx_frame #(
    parameter int         NUM_CH    = 4,
    parameter int         NONCE_W   = 64,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    proto_tx_frame_if.slave    bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NB    = NONCE_W / 8;
`ifdef PROTO_TX_CHKSUM_EN
    localparam int CHK_LEN = 1;
`else
    localparam int CHK_LEN = 0;
`endif
    localparam int IDX_W = $clog2(NB + 3) + 1;
    localparam logic [IDX_W-1:0] LAST_NF = IDX_W'(1 + CHK_LEN);
    localparam logic [IDX_W-1:0] LAST_F  = IDX_W'(1 + NB + CHK_LEN);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CH_W-1:0]     rr_ptr_r;
    logic [2:0]          seq_r;
    logic [IDX_W-1:0]    byte_idx_r;
    logic [IDX_W-1:0]    last_idx_r;
    logic                found_r;
    logic [CH_W-1:0]     ch_r;
    logic [NONCE_W-1:0]  nonce_sh_r;
    logic                send_r;
    logic [7:0]          tx_data_r;
    logic                frame_busy_r;
`ifdef PROTO_TX_CHKSUM_EN
    logic [7:0]          chk_r;

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    logic                grant_ok_s;
    logic [CH_W-1:0]     grant_s;
    logic [CH_W:0]       cand_s;
    logic [NONCE_W-1:0]  nonce_sel_s;
    logic [NUM_CH-1:0]   ready_s;
    logic                capture_s;
    logic                launch_s;
    logic                done_s;
    logic                last_s;
    logic [7:0]          status_s;
    logic [7:0]          cur_byte_s;

    assign bus.res_ready  = ready_s;
    assign bus.send       = send_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.frame_busy = frame_busy_r;

    // Round-robin grant: reverse scan so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_ok_s = 1'b0;
        grant_s    = '0;
        cand_s     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand_s     = {1'b0, rr_ptr_r} + (CH_W+1)'(k);
            cand_s     = (cand_s >= (CH_W+1)'(NUM_CH)) ? cand_s - (CH_W+1)'(NUM_CH) : cand_s;
            grant_ok_s = bus.res_valid[cand_s[CH_W-1:0]] ? 1'b1 : grant_ok_s;
            grant_s    = bus.res_valid[cand_s[CH_W-1:0]] ? cand_s[CH_W-1:0] : grant_s;
        end
    end

    // Nonce of the granted channel.
    always_comb begin
        nonce_sel_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nonce_sel_s = (grant_s == CH_W'(i)) ? bus.res_nonce[i*NONCE_W +: NONCE_W] : nonce_sel_s;
        end
    end

    // One-hot ready toward the granted channel, only while idle.
    always_comb begin
        ready_s = '0;
        if ((state_r == IDLE) && grant_ok_s) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign capture_s = (state_r == IDLE) && grant_ok_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:      state_nxt_s = capture_s ? SEND : IDLE;
            SEND:      state_nxt_s = bus.tx_busy ? SEND : WAIT_ACK;
            WAIT_ACK:  state_nxt_s = bus.tx_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: begin
                if (bus.tx_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else begin
                    state_nxt_s = last_s ? IDLE : SEND;
                end
            end
            default:   state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode and current frame byte selection.
    always_comb begin
        launch_s = (state_r == SEND) && !bus.tx_busy;
        done_s   = (state_r == WAIT_DONE) && !bus.tx_busy;
        last_s   = (byte_idx_r == last_idx_r);
        status_s = {found_r, seq_r, 4'(ch_r)};
        if (byte_idx_r == IDX_W'(0)) begin
            cur_byte_s = SYNC_BYTE;
        end else if (byte_idx_r == IDX_W'(1)) begin
            cur_byte_s = status_s;
`ifdef PROTO_TX_CHKSUM_EN
        end else if (last_s) begin
            cur_byte_s = chk_r;
`endif
        end else begin
            cur_byte_s = nonce_sh_r[7:0];
        end
    end

    // Frame datapath, registered UART outputs and per-frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r     <= '0;
            seq_r        <= 3'd0;
            byte_idx_r   <= '0;
            last_idx_r   <= '0;
            found_r      <= 1'b0;
            ch_r         <= '0;
            nonce_sh_r   <= '0;
            send_r       <= 1'b0;
            tx_data_r    <= 8'h00;
            frame_busy_r <= 1'b0;
`ifdef PROTO_TX_CHKSUM_EN
            chk_r        <= 8'h00;
`endif
        end else begin
            send_r <= launch_s;
            if (capture_s) begin
                found_r      <= bus.res_found[grant_s];
                ch_r         <= grant_s;
                nonce_sh_r   <= nonce_sel_s;
                byte_idx_r   <= '0;
                last_idx_r   <= bus.res_found[grant_s] ? LAST_F : LAST_NF;
                frame_busy_r <= 1'b1;
`ifdef PROTO_TX_CHKSUM_EN
                chk_r        <= 8'h00;
`endif
            end else if (launch_s) begin
                tx_data_r <= cur_byte_s;
                // Nonce bytes are consumed from the bottom of the shift register.
                nonce_sh_r <= (byte_idx_r > IDX_W'(1)) ? (nonce_sh_r >> 8) : nonce_sh_r;
`ifdef PROTO_TX_CHKSUM_EN
                chk_r     <= chk_fold(chk_r, cur_byte_s);
`endif
            end else if (done_s) begin
                if (last_s) begin
                    frame_busy_r <= 1'b0;
                    seq_r        <= seq_r + 3'd1;
                    rr_ptr_r     <= (ch_r == CH_W'(NUM_CH - 1)) ? '0 : ch_r + CH_W'(1);
                end else begin
                    byte_idx_r   <= byte_idx_r + IDX_W'(1);
                end
            end else begin
                byte_idx_r <= byte_idx_r;
            end
        end
    end
endmodule

// File: tb/tb_proto_tx_frame.sv
// Scoreboard bench for proto_tx_frame: expected bytes and grants queued at issue,
// checked by an independent monitor whenever the DUT launches a byte or accepts a result.
module tb_proto_tx_frame;
    localparam int NUM_CH  = 4;
    localparam int NONCE_W = 64;
`ifdef PROTO_TX_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proto_tx_frame_if #(.NUM_CH(NUM_CH), .NONCE_W(NONCE_W)) bus();

    proto_tx_frame #(.NUM_CH(NUM_CH), .NONCE_W(NONCE_W), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int         grant_q[$];
    int req_cnt[NUM_CH]   = '{default: 0};
    int done_cnt[NUM_CH]  = '{default: 0};
    int ready_cnt[NUM_CH] = '{default: 0};
    int send_cnt = 0;
    bit uart_stall = 1'b0;
    int exp_seq = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected frame bytes from the bench model; max_bytes truncates an aborted frame.
    task automatic push_frame(input int ch, input bit found, input logic [63:0] nonce,
                              input int max_bytes, output int len);
        logic [7:0] fb[$];
        logic [7:0] x;
        fb.push_back(8'hA5);
        fb.push_back({found, 3'(exp_seq), 4'(ch)});
        if (found) begin
            for (int i = 0; i < 8; i++) fb.push_back(nonce[i*8 +: 8]);
        end
        if (CHK) begin
            x = 8'h00;
            foreach (fb[i]) x = x ^ fb[i];
            fb.push_back(x);
        end
        len = fb.size();
        for (int i = 0; i < fb.size() && i < max_bytes; i++) exp_q.push_back(fb[i]);
        grant_q.push_back(ch);
        exp_seq = (exp_seq + 1) % 8;
    endtask

    task automatic issue(input int ch, input bit found, input logic [63:0] nonce);
        bus.res_found[ch] = found;
        bus.res_nonce[ch*NONCE_W +: NONCE_W] = nonce;
        req_cnt[ch]++;
    endtask

    function automatic bit all_quiet();
        bit q;
        q = !bus.frame_busy && !bus.tx_busy && (exp_q.size() == 0);
        for (int i = 0; i < NUM_CH; i++) q = q && (req_cnt[i] == done_cnt[i]);
        return q;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (c < budget && !all_quiet()) begin
            @(negedge clk);
            c++;
        end
        check({name, "_complete"}, 64'(c < budget), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_seq = 0;
    endtask

    // Result sources: valid stays up until each issued request is accepted.
    initial begin
        logic [NUM_CH-1:0] hs;
        bus.res_valid = '0;
        hs = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (hs[i]) done_cnt[i]++;
                bus.res_valid[i] = (req_cnt[i] != done_cnt[i]);
            end
            @(negedge clk);
            hs = rst ? '0 : (bus.res_valid & bus.res_ready);
        end
    end

    // UART model: busy one cycle after send, held 10 cycles; stall leaves busy low.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.send === 1'b1 && !rst) begin
                while (uart_stall) @(negedge clk);
                @(negedge clk);
                bus.tx_busy = 1'b1;
                repeat (10) @(negedge clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    // Monitor: pops expected bytes on send and expected grants on handshake.
    initial begin
        bit prev_send;
        logic [NUM_CH-1:0] hs;
        int g;
        logic [7:0] e;
        prev_send = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.send === 1'b1) begin
                    send_cnt++;
                    check("send_single_cycle", 64'(prev_send), 64'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_send: got byte %0h, expected no send", bus.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 64'(bus.tx_data), 64'(e));
                    end
                end
                prev_send = (bus.send === 1'b1);
                if (bus.res_ready != '0) begin
                    check("ready_onehot", 64'($countones(bus.res_ready)), 64'd1);
                end
                for (int i = 0; i < NUM_CH; i++) ready_cnt[i] += int'(bus.res_ready[i]);
                hs = bus.res_valid & bus.res_ready;
                if (hs != '0) begin
                    g = -1;
                    for (int i = NUM_CH - 1; i >= 0; i--) if (hs[i]) g = i;
                    if (grant_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got ch %0d, expected none", g);
                    end else begin
                        check("grant_ch", 64'(g), 64'(grant_q.pop_front()));
                    end
                end
            end else begin
                prev_send = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, len2, base, base_r, c;
        bus.res_found = '0;
        bus.res_nonce = '0;
        repeat (3) @(negedge clk);
        check("rst_send", 64'(bus.send), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'h00);
        check("rst_frame_busy", 64'(bus.frame_busy), 64'd0);
        check("rst_res_ready", 64'(bus.res_ready), 64'd0);
        rst = 1'b0;

        // Not-found frame on ch1.
        base = send_cnt;
        base_r = ready_cnt[1];
        push_frame(1, 1'b0, 64'd0, 99, len);
        issue(1, 1'b0, 64'd0);
        wait_done("t1", 300);
        check("t1_send_count", 64'(send_cnt - base), 64'(len));
        check("t1_ready_pulses", 64'(ready_cnt[1] - base_r), 64'd1);

        // Found frame on ch2.
        do_reset();
        base = send_cnt;
        push_frame(2, 1'b1, 64'h0123456789ABCDEF, 99, len);
        issue(2, 1'b1, 64'h0123456789ABCDEF);
        wait_done("t2", 600);
        check("t2_send_count", 64'(send_cnt - base), 64'(len));

        // Round-robin from rr_ptr=1.
        do_reset();
        push_frame(0, 1'b0, 64'd0, 99, len);
        issue(0, 1'b0, 64'd0);
        wait_done("t3a", 300);
        push_frame(3, 1'b0, 64'd0, 99, len);
        push_frame(0, 1'b0, 64'd0, 99, len);
        issue(0, 1'b0, 64'd0);
        issue(3, 1'b0, 64'd0);
        wait_done("t3b", 600);
        push_frame(2, 1'b0, 64'd0, 99, len);
        push_frame(0, 1'b0, 64'd0, 99, len);
        issue(0, 1'b0, 64'd0);
        issue(2, 1'b0, 64'd0);
        wait_done("t3c", 600);

        // Sequence wrap over nine back-to-back frames.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push_frame(0, 1'b0, 64'd0, 99, len);
            issue(0, 1'b0, 64'd0);
        end
        wait_done("t4", 3000);

        // Busy never rises after send: no second launch until released.
        uart_stall = 1'b1;
        base = send_cnt;
        push_frame(2, 1'b0, 64'd0, 99, len);
        issue(2, 1'b0, 64'd0);
        c = 0;
        while (c < 100 && send_cnt == base) begin
            @(negedge clk);
            c++;
        end
        check("t5_first_send", 64'(c < 100), 64'd1);
        repeat (20) @(negedge clk);
        check("t5_no_resend", 64'(send_cnt - base), 64'd1);
        check("t5_frame_busy", 64'(bus.frame_busy), 64'd1);
        uart_stall = 1'b0;
        wait_done("t5", 300);
        check("t5_send_count", 64'(send_cnt - base), 64'(len));

        // Reset after byte 3 of a found frame.
        base = send_cnt;
        push_frame(2, 1'b1, 64'hFEDCBA9876543210, 4, len);
        issue(2, 1'b1, 64'hFEDCBA9876543210);
        c = 0;
        while (c < 400 && (send_cnt - base) < 4) begin
            @(negedge clk);
            c++;
        end
        check("t6_four_bytes", 64'(c < 400), 64'd1);
        rst = 1'b1;
        exp_seq = 0;
        repeat (2) @(negedge clk);
        check("t6_rst_send", 64'(bus.send), 64'd0);
        check("t6_rst_frame_busy", 64'(bus.frame_busy), 64'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t6_no_more_bytes", 64'(send_cnt - base), 64'd4);
        wait_done("t6a", 100);
        push_frame(1, 1'b0, 64'd0, 99, len);
        push_frame(3, 1'b0, 64'd0, 99, len2);
        issue(1, 1'b0, 64'd0);
        issue(3, 1'b0, 64'd0);
        wait_done("t6b", 600);

        check("exp_bytes_drained", 64'(exp_q.size()), 64'd0);
        check("exp_grants_drained", 64'(grant_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
